cpu_rf_mp: RTL and testbench
============================

CPU_RF_MP -- requirements
Module: cpu_rf_mp

Interface
REQ-001 Parameter DATA_W, 16, register width in bits.
REQ-002 Parameter NREGS, 8, register count (power of two, >=2); AW = clog2(NREGS).
REQ-003 Parameter ZERO_R0, 0, 1 = register 0 hardwired to zero.
REQ-004 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 rd_a_sel, rd_b_sel  in  AW  read-port register selects.
REQ-008 rd_a_data, rd_b_data  out  DATA_W  read data, combinational.
REQ-009 wr0_en, wr1_en  in  1  write enables, port 0 / port 1.
REQ-010 wr0_sel, wr1_sel  in  AW  write register selects.
REQ-011 wr0_data, wr1_data  in  DATA_W  write data.
REQ-012 busy_set  in  1  mark register busy_set_sel as pending (outstanding load).
REQ-013 busy_set_sel  in  AW  register to mark busy.
REQ-014 busy_a, busy_b  out  1  pending bit of rd_a_sel / rd_b_sel, combinational.
REQ-015 clr_req  in  1  request bulk clear of all registers.
REQ-016 clr_busy  out  1  bulk clear in progress.
REQ-017 clr_done  out  1  one-cycle pulse at bulk-clear completion.

Function
REQ-018 Reads: asynchronous; rd_x_data = reg[rd_x_sel]; all selects fully decoded, no latches.
REQ-019 Writes: reg[wrN_sel] <= wrN_data at rising edge when wrN_en=1; both ports may write different registers in one cycle.
REQ-020 Write collision (both enabled, same sel): port 1 data wins.
REQ-021 BYPASS=1: read of a register being written this cycle returns write data (port 1 priority); BYPASS=0: returns stored value.
REQ-022 ZERO_R0=1: register 0 reads 0, writes ignored, busy bit always 0, never bypassed.
REQ-023 Scoreboard: one busy bit per register; busy_set sets bit next edge; any write to a register clears its bit next edge.
REQ-024 busy_set and write to same register same cycle: bit ends set (set wins).
REQ-025 busy_x reflects stored bit only (no bypass of set/clear).
REQ-026 Clear FSM states IDLE, CLEAR, DONE; IDLE -> CLEAR on clr_req, index=0.
REQ-027 CLEAR: each cycle writes 0 to reg[index], clears busy[index], index increments; at index NREGS-1 -> DONE.
REQ-028 DONE: clr_done=1 one cycle, -> IDLE; total NREGS+1 cycles from clr_req edge to clr_done.
REQ-029 clr_busy=1 in CLEAR and DONE; while 1, write ports and busy_set are ignored, reads remain valid.
REQ-030 clr_req in CLEAR or DONE ignored; clr_req held high re-triggers only from IDLE.
REQ-031 Bypass disabled while clr_busy=1.

Reset
REQ-032 reset_n=0 asynchronously: all registers 0, busy bits 0, FSM IDLE, index 0, clr_busy 0, clr_done 0.
REQ-033 Reset during CLEAR aborts sequence; no clr_done pulse issued.

Structure
REQ-034 Package cpu_rf_pkg holds clear-FSM state enum and default parameter constants.
REQ-035 Clear FSM and index counter in sub-module cpu_rf_clr_seq; storage, ports, scoreboard in cpu_rf_mp.

Verification
REQ-036 Defaults; write R3=0x1234 port 0, next cycle read A=3 -> 0x1234; same-cycle read A=3 with BYPASS=1 -> 0x1234, BYPASS=0 -> old value.
REQ-037 wr0 R5=0xAAAA and wr1 R5=0x5555 same cycle -> R5=0x5555; concurrent R2/R6 writes both land.
REQ-038 busy_set R4 -> busy_a(sel 4)=1 next cycle; write R4=0x0001 -> busy 0; busy_set R4 plus write R4 same cycle -> busy 1, data 0x0001.
REQ-039 Load R0..R7=0xFFFF, busy R1, clr_req -> clr_busy 8 cycles, clr_done on 9th, all regs 0, busy 0; writes during clear ignored.
REQ-040 ZERO_R0=1: write R0=0xBEEF -> reads 0; busy_set R0 -> busy 0.
REQ-041 reset_n low at clear index 3 -> regs 0, FSM IDLE, no clr_done pulse.

Source files
------------

// File: rtl/cpu_rf_pkg.sv
// -----------------------------------------------------------------------------
// cpu_rf_pkg
// Shared definitions for the multi-port register file: the bulk-clear
// sequencer state encoding and the default parameter values used by the
// register file, its bus interface and the clear sequencer.
// -----------------------------------------------------------------------------
package cpu_rf_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_NREGS   = 8;
  localparam bit          DEF_ZERO_R0 = 1'b0;
  localparam bit          DEF_BYPASS  = 1'b1;

  // Bulk-clear sequencer states
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/cpu_rf_mp_if.sv
// -----------------------------------------------------------------------------
// cpu_rf_mp_if
// Bus bundle of the multi-port register file.
//   read ports  : rd_a_sel/rd_b_sel -> rd_a_data/rd_b_data, busy_a/busy_b
//   write ports : wr0_en/wr0_sel/wr0_data, wr1_en/wr1_sel/wr1_data
//   scoreboard  : busy_set/busy_set_sel
//   bulk clear  : clr_req -> clr_busy, clr_done
// master = user of the register file, slave = the register file itself.
// -----------------------------------------------------------------------------
interface cpu_rf_mp_if
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = $clog2(DEF_NREGS)
);

  logic [AW-1:0]     rd_a_sel;
  logic [AW-1:0]     rd_b_sel;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic              wr0_en;
  logic [AW-1:0]     wr0_sel;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [AW-1:0]     wr1_sel;
  logic [DATA_W-1:0] wr1_data;
  logic              busy_set;
  logic [AW-1:0]     busy_set_sel;
  logic              busy_a;
  logic              busy_b;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_a_sel, rd_b_sel,
    output wr0_en, wr0_sel, wr0_data,
    output wr1_en, wr1_sel, wr1_data,
    output busy_set, busy_set_sel,
    output clr_req,
    input  rd_a_data, rd_b_data, busy_a, busy_b, clr_busy, clr_done
  );

  modport slave (
    input  rd_a_sel, rd_b_sel,
    input  wr0_en, wr0_sel, wr0_data,
    input  wr1_en, wr1_sel, wr1_data,
    input  busy_set, busy_set_sel,
    input  clr_req,
    output rd_a_data, rd_b_data, busy_a, busy_b, clr_busy, clr_done
  );

endinterface

// File: rtl/cpu_rf_clr_seq.sv
// -----------------------------------------------------------------------------
// cpu_rf_clr_seq
// Bulk-clear sequencer: on a clear request from IDLE it walks an index over
// every register (one per cycle), then spends one cycle in DONE.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_clr_req     : start request, honoured only in IDLE
//   o_clr_busy    : high in CLEAR and DONE (registered)
//   o_clr_done    : one-cycle completion pulse in DONE (registered)
//   o_clr_we      : zero-write strobe for register o_clr_idx
//   o_clr_idx     : register currently being cleared
// -----------------------------------------------------------------------------
module cpu_rf_clr_seq
  import cpu_rf_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clr_req,
  output logic                     o_clr_busy,
  output logic                     o_clr_done,
  output logic                     o_clr_we,
  output logic [$clog2(NREGS)-1:0] o_clr_idx
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREGS - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic          r_clr_busy;
  logic          r_clr_done;

  // Next-state and next-index decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_CLEAR;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = CLR_IDLE;
          w_idx_nxt   = r_idx;
        end
      end
      CLR_CLEAR: begin
        // The last register is cleared on the same edge that enters DONE
        if (r_idx == IDX_LAST) begin
          w_state_nxt = CLR_DONE;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = CLR_CLEAR;
          w_idx_nxt   = r_idx + IDX_ONE;
        end
      end
      CLR_DONE: begin
        // Requests seen here are dropped; a held request re-triggers from IDLE
        w_state_nxt = CLR_IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = CLR_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State, index and registered status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= CLR_IDLE;
      r_idx      <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_clr_busy <= (w_state_nxt != CLR_IDLE);
      r_clr_done <= (w_state_nxt == CLR_DONE);
    end
  end

  assign o_clr_busy = r_clr_busy;
  assign o_clr_done = r_clr_done;
  assign o_clr_we   = (r_state == CLR_CLEAR);
  assign o_clr_idx  = r_idx;

endmodule

// File: rtl/cpu_rf_mp.sv
// -----------------------------------------------------------------------------
// cpu_rf_mp
// Two-read / two-write register file with a per-register pending ("busy")
// scoreboard and a sequenced bulk clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : read selects/data, write ports 0/1, busy_set, busy flags,
//                  clr_req / clr_busy / clr_done
// Reads are combinational. With BYPASS=1 a read of a register being written
// in the same cycle returns the write data (port 1 first). With ZERO_R0=1
// register 0 is constant zero and never pending.
// -----------------------------------------------------------------------------
module cpu_rf_mp
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREGS   = DEF_NREGS,
  parameter bit ZERO_R0 = DEF_ZERO_R0,
  parameter bit BYPASS  = DEF_BYPASS
) (
  input logic         clk,
  input logic         reset_n,
  cpu_rf_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;

  logic              w_clr_busy;
  logic              w_clr_done;
  logic              w_clr_we;
  logic [AW-1:0]     w_clr_idx;

  logic              w_wr0_ok;
  logic              w_wr1_ok;
  logic              w_set_ok;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_busy_a;
  logic              w_busy_b;

  cpu_rf_clr_seq #(
    .NREGS (NREGS)
  ) u_clr_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr_req  (bus.clr_req),
    .o_clr_busy (w_clr_busy),
    .o_clr_done (w_clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  // Qualified requests: the clear owns the array, and register 0 is
  // untouchable when it is hardwired to zero
  always_comb begin
    w_wr0_ok = bus.wr0_en   && !w_clr_busy && !(ZERO_R0 && (bus.wr0_sel == '0));
    w_wr1_ok = bus.wr1_en   && !w_clr_busy && !(ZERO_R0 && (bus.wr1_sel == '0));
    w_set_ok = bus.busy_set && !w_clr_busy && !(ZERO_R0 && (bus.busy_set_sel == '0));
  end

  // Register storage: clear sweep, then port 1, then port 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_clr_we && (w_clr_idx == AW'(i))) begin
          r_regs[i] <= '0;
        end else if (w_wr1_ok && (bus.wr1_sel == AW'(i))) begin
          r_regs[i] <= bus.wr1_data;
        end else if (w_wr0_ok && (bus.wr0_sel == AW'(i))) begin
          r_regs[i] <= bus.wr0_data;
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Pending scoreboard: a set beats a same-cycle write to the same register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_clr_we && (w_clr_idx == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end else if (w_set_ok && (bus.busy_set_sel == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_wr0_ok && (bus.wr0_sel == AW'(i))) ||
                     (w_wr1_ok && (bus.wr1_sel == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end else begin
          r_busy[i] <= r_busy[i];
        end
      end
    end
  end

  // Read port A with optional same-cycle forwarding
  always_comb begin
    w_rd_a = r_regs[bus.rd_a_sel];
    if (ZERO_R0 && (bus.rd_a_sel == '0)) begin
      w_rd_a = '0;
    end else if (BYPASS && w_wr1_ok && (bus.wr1_sel == bus.rd_a_sel)) begin
      w_rd_a = bus.wr1_data;
    end else if (BYPASS && w_wr0_ok && (bus.wr0_sel == bus.rd_a_sel)) begin
      w_rd_a = bus.wr0_data;
    end else begin
      w_rd_a = r_regs[bus.rd_a_sel];
    end
  end

  // Read port B with optional same-cycle forwarding
  always_comb begin
    w_rd_b = r_regs[bus.rd_b_sel];
    if (ZERO_R0 && (bus.rd_b_sel == '0)) begin
      w_rd_b = '0;
    end else if (BYPASS && w_wr1_ok && (bus.wr1_sel == bus.rd_b_sel)) begin
      w_rd_b = bus.wr1_data;
    end else if (BYPASS && w_wr0_ok && (bus.wr0_sel == bus.rd_b_sel)) begin
      w_rd_b = bus.wr0_data;
    end else begin
      w_rd_b = r_regs[bus.rd_b_sel];
    end
  end

  // Pending flags show the stored bit only, never the in-flight set/clear
  always_comb begin
    w_busy_a = r_busy[bus.rd_a_sel];
    w_busy_b = r_busy[bus.rd_b_sel];
    if (ZERO_R0 && (bus.rd_a_sel == '0)) begin
      w_busy_a = 1'b0;
    end else begin
      w_busy_a = r_busy[bus.rd_a_sel];
    end
    if (ZERO_R0 && (bus.rd_b_sel == '0)) begin
      w_busy_b = 1'b0;
    end else begin
      w_busy_b = r_busy[bus.rd_b_sel];
    end
  end

  assign bus.rd_a_data = w_rd_a;
  assign bus.rd_b_data = w_rd_b;
  assign bus.busy_a    = w_busy_a;
  assign bus.busy_b    = w_busy_b;
  assign bus.clr_busy  = w_clr_busy;
  assign bus.clr_done  = w_clr_done;

endmodule

// File: tb/tb_cpu_rf_mp.sv
// -----------------------------------------------------------------------------
// tb_cpu_rf_mp
// Drives identical stimulus into two register files: dut_a with the default
// configuration (BYPASS=1, ZERO_R0=0) and dut_b with BYPASS=0, ZERO_R0=1.
// A behavioural model predicts every output each cycle; predictions are
// queued by the driver and compared by a monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_rf_mp;
  import cpu_rf_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] s_rda, s_rdb, s_w0sel, s_w1sel, s_bsel;
  logic          s_w0en, s_w1en, s_bset, s_clr;
  logic [DW-1:0] s_w0d, s_w1d;

  cpu_rf_mp_if #(.DATA_W(DW), .AW(AW)) if_a ();
  cpu_rf_mp_if #(.DATA_W(DW), .AW(AW)) if_b ();

  assign if_a.rd_a_sel = s_rda;   assign if_b.rd_a_sel = s_rda;
  assign if_a.rd_b_sel = s_rdb;   assign if_b.rd_b_sel = s_rdb;
  assign if_a.wr0_en   = s_w0en;  assign if_b.wr0_en   = s_w0en;
  assign if_a.wr0_sel  = s_w0sel; assign if_b.wr0_sel  = s_w0sel;
  assign if_a.wr0_data = s_w0d;   assign if_b.wr0_data = s_w0d;
  assign if_a.wr1_en   = s_w1en;  assign if_b.wr1_en   = s_w1en;
  assign if_a.wr1_sel  = s_w1sel; assign if_b.wr1_sel  = s_w1sel;
  assign if_a.wr1_data = s_w1d;   assign if_b.wr1_data = s_w1d;
  assign if_a.busy_set = s_bset;  assign if_b.busy_set = s_bset;
  assign if_a.busy_set_sel = s_bsel; assign if_b.busy_set_sel = s_bsel;
  assign if_a.clr_req  = s_clr;   assign if_b.clr_req  = s_clr;

  cpu_rf_mp #(.DATA_W(DW), .NREGS(NR), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a));
  cpu_rf_mp #(.DATA_W(DW), .NREGS(NR), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b));

  // ---------------- reference model ----------------
  // Config 0 = dut_a (forwarding, normal R0); config 1 = dut_b (no forwarding, R0 zero)
  logic [DW-1:0] m_reg  [2][NR];
  logic          m_busy [2][NR];
  // Clear progress: 0 idle, k in 1..NR clearing register k-1, NR+1 completion cycle
  int            m_clr;

  typedef struct packed {
    logic [DW-1:0] rda0, rdb0, rda1, rdb1;
    logic          ba0, bb0, ba1, bb1, cb, cd;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_cyc  = 0;

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < NR; r++) begin
        m_reg[c][r]  = '0;
        m_busy[c][r] = 1'b0;
      end
    m_clr = 0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input int c, input logic [AW-1:0] sel);
    bit zr = (c == 1);
    bit bp = (c == 0);
    bit idle = (m_clr == 0);
    if (zr && sel == 3'd0) return '0;
    if (bp && idle && s_w1en && s_w1sel == sel) return s_w1d;
    if (bp && idle && s_w0en && s_w0sel == sel) return s_w0d;
    return m_reg[c][sel];
  endfunction

  function automatic logic exp_busy(input int c, input logic [AW-1:0] sel);
    if (c == 1 && sel == 3'd0) return 1'b0;
    return m_busy[c][sel];
  endfunction

  // Apply the effect of one rising edge with the current inputs
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (m_clr == 0) begin
      for (int c = 0; c < 2; c++) begin
        bit zr = (c == 1);
        if (s_w0en && !(zr && s_w0sel == 3'd0)) begin
          m_reg[c][s_w0sel] = s_w0d; m_busy[c][s_w0sel] = 1'b0;
        end
        if (s_w1en && !(zr && s_w1sel == 3'd0)) begin
          m_reg[c][s_w1sel] = s_w1d; m_busy[c][s_w1sel] = 1'b0;
        end
        if (s_bset && !(zr && s_bsel == 3'd0)) m_busy[c][s_bsel] = 1'b1;
      end
      if (s_clr) m_clr = 1;
    end else if (m_clr <= NR) begin
      for (int c = 0; c < 2; c++) begin
        m_reg[c][m_clr-1]  = '0;
        m_busy[c][m_clr-1] = 1'b0;
      end
      m_clr = m_clr + 1;
    end else begin
      m_clr = 0;
    end
  endtask

  // Queue this cycle's prediction, then advance across one rising edge
  task automatic step();
    exp_t e;
    e.rda0 = exp_rd(0, s_rda);   e.rdb0 = exp_rd(0, s_rdb);
    e.rda1 = exp_rd(1, s_rda);   e.rdb1 = exp_rd(1, s_rdb);
    e.ba0  = exp_busy(0, s_rda); e.bb0  = exp_busy(0, s_rdb);
    e.ba1  = exp_busy(1, s_rda); e.bb1  = exp_busy(1, s_rdb);
    e.cb   = (m_clr != 0);
    e.cd   = (m_clr == NR + 1);
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic w0en, input logic [AW-1:0] w0sel, input logic [DW-1:0] w0d,
                     input logic w1en, input logic [AW-1:0] w1sel, input logic [DW-1:0] w1d,
                     input logic bset, input logic [AW-1:0] bsel, input logic clr,
                     input logic [AW-1:0] rda, input logic [AW-1:0] rdb);
    s_w0en = w0en; s_w0sel = w0sel; s_w0d = w0d;
    s_w1en = w1en; s_w1sel = w1sel; s_w1d = w1d;
    s_bset = bset; s_bsel = bsel; s_clr = clr;
    s_rda = rda; s_rdb = rdb;
    step();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, a, b);
  endtask

  // Reset asserted asynchronously in mid-cycle, held for n cycles
  task automatic do_reset(input int n);
    s_w0en = 1'b0; s_w1en = 1'b0; s_bset = 1'b0; s_clr = 1'b0;
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) step();
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, mon_cyc, act, exp);
    end
  endtask

  // Compare every DUT output against the oldest queued prediction
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("a.rd_a",     if_a.rd_a_data,       e.rda0);
      chk("a.rd_b",     if_a.rd_b_data,       e.rdb0);
      chk("b.rd_a",     if_b.rd_a_data,       e.rda1);
      chk("b.rd_b",     if_b.rd_b_data,       e.rdb1);
      chk("a.busy_a",   16'(if_a.busy_a),     16'(e.ba0));
      chk("a.busy_b",   16'(if_a.busy_b),     16'(e.bb0));
      chk("b.busy_a",   16'(if_b.busy_a),     16'(e.ba1));
      chk("b.busy_b",   16'(if_b.busy_b),     16'(e.bb1));
      chk("a.clr_busy", 16'(if_a.clr_busy),   16'(e.cb));
      chk("a.clr_done", 16'(if_a.clr_done),   16'(e.cd));
      chk("b.clr_busy", 16'(if_b.clr_busy),   16'(e.cb));
      chk("b.clr_done", 16'(if_b.clr_done),   16'(e.cd));
      mon_cyc++;
    end
  end

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    s_rda = 3'd0; s_rdb = 3'd0; s_w0sel = 3'd0; s_w1sel = 3'd0; s_bsel = 3'd0;
    s_w0en = 1'b0; s_w1en = 1'b0; s_bset = 1'b0; s_clr = 1'b0;
    s_w0d = 16'h0; s_w1d = 16'h0;
    model_reset();
    @(posedge clk); #1;
    do_reset(2);
    rd(3'd1, 3'd6);

    // Write R3, same-cycle read (forwarded on dut_a, old value on dut_b)
    cyc(1'b1, 3'd3, 16'h1111, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3);
    cyc(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd0);
    rd(3'd3, 3'd3);

    // Collision on R5 (port 1 wins), then concurrent R2/R6
    cyc(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd5, 3'd5);
    cyc(1'b1, 3'd2, 16'h2222, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 1'b0, 3'd5, 3'd2);
    rd(3'd2, 3'd6);

    // Scoreboard on R4: set, write clears, set+write leaves set
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4);
    cyc(1'b1, 3'd4, 16'h0001, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);
    cyc(1'b1, 3'd4, 16'h0001, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4);
    rd(3'd4, 3'd4);

    // Register 0 write and busy_set (ignored on dut_b)
    cyc(1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0);
    rd(3'd0, 3'd0);

    // Fill all registers, mark R1 pending, then bulk clear with writes,
    // busy_sets and a held request thrown at it
    for (int i = 0; i < NR; i += 2)
      cyc(1'b1, 3'(i), 16'hFFFF, 1'b1, 3'(i + 1), 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'(i), 3'(i + 1));
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd1, 3'd7);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd1, 3'd0);
    for (int k = 0; k < NR + 1; k++)
      cyc(1'b1, 3'(k), 16'h1357, 1'b1, 3'd7, 16'hABCD, 1'b1, 3'(k), (k < 4) ? 1'b1 : 1'b0,
          3'(k), 3'd1);
    for (int i = 0; i < NR; i++) rd(3'(i), 3'(NR - 1 - i));

    // Reset while the sweep is at index 3
    for (int i = 0; i < NR; i++)
      cyc(1'b1, 3'(i), 16'h0F0F, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0, 3'(i), 3'd0);
    cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd3, 3'd4);
    for (int i = 0; i < 3; i++) rd(3'd3, 3'd4);
    do_reset(1);
    for (int i = 0; i < 12; i++) rd(3'(i % NR), 3'((i + 3) % NR));

    // Randomised traffic with occasional clears
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, NR - 1)), 16'($urandom),
          1'($urandom_range(0, 1)), 3'($urandom_range(0, NR - 1)), 16'($urandom),
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, NR - 1)),
          ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
          3'($urandom_range(0, NR - 1)), 3'($urandom_range(0, NR - 1)));
    end
    rd(3'd0, 3'd1);

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
